// File: rtl/sdram_sim_multiport.sv
// Cycle-accurate behavioural model of the GameTank SDRAM controller.
// Byte ports are served in the phase-1 slot and the 16-bit RV port in the
// phase-0 slot. Optional refresh stalls hold off both slots. No SDRAM pins.
module sdram_sim_multiport #(
  parameter int NUM_PORTS        = 2,
  parameter int ADDR_W           = 22,
  parameter int RV_ADDR_W        = 20,
  parameter int REFRESH_INTERVAL = 0,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        clkref,
  output logic                        busy,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS-1:0]        oe,
  input  logic [NUM_PORTS*8-1:0]      din,
  output logic [NUM_PORTS*8-1:0]      dout,
  input  logic [RV_ADDR_W-1:0]        rv_addr,
  input  logic [15:0]                 rv_din,
  input  logic [1:0]                  rv_ds,
  input  logic                        rv_we,
  input  logic                        rv_req,
  output logic                        rv_req_ack,
  output logic [15:0]                 rv_dout
);

  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BUSY_W = $clog2(REFRESH_CYCLES + 1);

  // Memories are never reset: contents survive resetn.
  logic [7:0]  mem    [0:(1<<ADDR_W)-1];
  logic [15:0] mem_rv [0:(1<<RV_ADDR_W)-1];

  logic                 phase;
  logic                 clkref_d;
  logic [NUM_PORTS-1:0] we_d, oe_d, port_edge, pend, lat_we;
  logic [ADDR_W-1:0]    lat_addr [NUM_PORTS];
  logic [7:0]           lat_din  [NUM_PORTS];
  logic [7:0]           dout_q   [NUM_PORTS];
  logic [PORT_W-1:0]    sel;
  logic                 sel_valid;
  logic                 byte_go, rv_go;
  logic                 rd_pend;
  logic [PORT_W-1:0]    rd_port;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rv_rd_pend;
  logic [RV_ADDR_W-1:0] rv_rd_addr;
  logic [BUSY_W-1:0]    busy_cnt;

  assign port_edge = (oe & ~oe_d) | (we & ~we_d);
  assign busy      = (busy_cnt != '0);

  // Slots are gated by resetn so a reset edge can never complete a request.
  assign byte_go = resetn & phase & ~busy & sel_valid;
  assign rv_go   = resetn & ~phase & ~busy & (rv_req != rv_req_ack);

  // Highest-index pending port wins the phase-1 slot.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pend[i]) begin
        sel_valid = 1'b1;
        sel       = PORT_W'(i);
      end
    end
  end

  // Slot phase: free-running toggle, realigned to 0 on a clkref rising edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      phase    <= 1'b0;
      clkref_d <= clkref;
    end else begin
      clkref_d <= clkref;
      phase    <= (clkref & ~clkref_d) ? 1'b0 : ~phase;
    end
  end

  // Byte-port edge capture; a new edge overwrites a still-pending request.
  always_ff @(posedge clk) begin
    we_d <= we;
    oe_d <= oe;
    if (!resetn) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (port_edge[i]) begin
          pend[i]     <= 1'b1;
          lat_we[i]   <= we[i];
          lat_addr[i] <= addr[i*ADDR_W +: ADDR_W];
          lat_din[i]  <= din[i*8 +: 8];
        end else if (byte_go && sel == PORT_W'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Byte memory write in the phase-1 slot.
  always_ff @(posedge clk) begin
    if (byte_go && lat_we[sel]) mem[lat_addr[sel]] <= lat_din[sel];
  end

  // Byte read: slot registers the address, data lands on the following clk.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) dout_q[i] <= 8'h00;
    end else begin
      rd_pend <= byte_go & ~lat_we[sel];
      rd_port <= sel;
      rd_addr <= lat_addr[sel];
      if (rd_pend) dout_q[rd_port] <= mem[rd_addr];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_dout
    assign dout[g*8 +: 8] = dout_q[g];
  end

  // RV memory write with per-byte strobes in the phase-0 slot.
  always_ff @(posedge clk) begin
    if (rv_go && rv_we) begin
      if (rv_ds[1]) mem_rv[rv_addr][15:8] <= rv_din[15:8];
      if (rv_ds[0]) mem_rv[rv_addr][7:0]  <= rv_din[7:0];
    end
  end

  // RV handshake: ack follows rv_req at service, read data one clk later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rv_req_ack <= 1'b0;
      rv_rd_pend <= 1'b0;
      rv_dout    <= 16'h0000;
    end else begin
      rv_rd_pend <= rv_go & ~rv_we;
      rv_rd_addr <= rv_addr;
      if (rv_go)      rv_req_ack <= rv_req;
      if (rv_rd_pend) rv_dout    <= mem_rv[rv_rd_addr];
    end
  end

  if (REFRESH_INTERVAL > 0) begin : g_refresh
    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    logic [CNT_W-1:0] ref_cnt;

    // Refresh timer: wraps at INTERVAL-1 and opens a REFRESH_CYCLES stall.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        ref_cnt  <= '0;
        busy_cnt <= '0;
      end else if (ref_cnt == CNT_W'(REFRESH_INTERVAL - 1)) begin
        ref_cnt  <= '0;
        busy_cnt <= BUSY_W'(REFRESH_CYCLES);
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
        if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      end
    end
  end else begin : g_no_refresh
    assign busy_cnt = '0;
  end

endmodule

// File: tb/tb_sdram_sim_multiport.sv
// Directed bench: main instance with refresh off, second instance with
// REFRESH_INTERVAL=16 / REFRESH_CYCLES=4. Expected values are hand-computed
// from the slot timing (edge n = n-th rising clk since time 0).
module tb_sdram_sim_multiport;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  // main instance
  logic        resetn = 1'b0, clkref = 1'b0, busy;
  logic [43:0] addr = '0;
  logic [1:0]  we = '0, oe = '0;
  logic [15:0] din = '0, dout;
  logic [19:0] rv_addr = '0;
  logic [15:0] rv_din = '0, rv_dout;
  logic [1:0]  rv_ds = '0;
  logic        rv_we = 1'b0, rv_req = 1'b0, rv_req_ack;

  // refresh instance
  logic        resetn_r = 1'b0, clkref_r = 1'b0, busy_r;
  logic [23:0] addr_r = '0;
  logic [1:0]  we_r = '0, oe_r = '0;
  logic [15:0] din_r = '0, dout_r;
  logic [7:0]  rv_addr_r = '0;
  logic [15:0] rv_din_r = '0, rv_dout_r;
  logic [1:0]  rv_ds_r = '0;
  logic        rv_we_r = 1'b0, rv_req_r = 1'b0, rv_req_ack_r;

  always #5 clk = ~clk;

  sdram_sim_multiport u_dut (
    .clk(clk), .resetn(resetn), .clkref(clkref), .busy(busy),
    .addr(addr), .we(we), .oe(oe), .din(din), .dout(dout),
    .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we),
    .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout)
  );

  sdram_sim_multiport #(
    .NUM_PORTS(2), .ADDR_W(12), .RV_ADDR_W(8),
    .REFRESH_INTERVAL(16), .REFRESH_CYCLES(4)
  ) u_ref (
    .clk(clk), .resetn(resetn_r), .clkref(clkref_r), .busy(busy_r),
    .addr(addr_r), .we(we_r), .oe(oe_r), .din(din_r), .dout(dout_r),
    .rv_addr(rv_addr_r), .rv_din(rv_din_r), .rv_ds(rv_ds_r), .rv_we(rv_we_r),
    .rv_req(rv_req_r), .rv_req_ack(rv_req_ack_r), .rv_dout(rv_dout_r)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    // reset through edges 1..3
    go_to(3);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_rv_dout", rv_dout, 16'h0000);
    chk("rst_ack", {15'd0, rv_req_ack}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);

    // port0 write 0x5A @0x123: capture edge 4, phase-1 slot edge 5
    resetn = 1'b1;
    we[0] = 1'b1; addr[21:0] = 22'h000123; din[7:0] = 8'h5A;
    go_to(5);
    we[0] = 1'b0;
    oe[0] = 1'b1;                      // read edge captured at 6, slot 7, data 8
    go_to(6);
    oe[0] = 1'b0;
    go_to(7);
    chk("p0_rd_early", dout, 16'h0000);
    go_to(8);
    chk("p0_rd_5a", dout, 16'h005A);

    // simultaneous writes then simultaneous reads: port1 before port0
    we = 2'b11;
    addr[21:0] = 22'h000010; din[7:0] = 8'h11;
    addr[43:22] = 22'h000020; din[15:8] = 8'h22;
    go_to(9);
    we = 2'b00;
    go_to(13);
    oe = 2'b11;                        // capture 14, port1 slot 15, port0 slot 17
    go_to(14);
    oe = 2'b00;
    go_to(16);
    chk("dual_p1_first", dout, 16'h225A);
    go_to(17);
    chk("dual_p0_wait", dout, 16'h225A);
    go_to(18);
    chk("dual_p0_next", dout, 16'h2211);

    // RV write 0xBEEF ds=11: phase-0 slot at edge 20
    rv_addr = 20'h00040; rv_din = 16'hBEEF; rv_ds = 2'b11; rv_we = 1'b1; rv_req = 1'b1;
    go_to(19);
    chk("rv_w1_pre", {15'd0, rv_req_ack}, 16'h0000);
    go_to(20);
    chk("rv_w1_ack", {15'd0, rv_req_ack}, 16'h0001);
    rv_din = 16'h1234; rv_ds = 2'b01; rv_req = 1'b0;
    go_to(21);
    chk("rv_w2_pre", {15'd0, rv_req_ack}, 16'h0001);
    go_to(22);
    chk("rv_w2_ack", {15'd0, rv_req_ack}, 16'h0000);
    rv_we = 1'b0; rv_req = 1'b1;
    go_to(24);
    chk("rv_rd_ack", {15'd0, rv_req_ack}, 16'h0001);
    chk("rv_rd_early", rv_dout, 16'h0000);
    go_to(25);
    chk("rv_rd_mask", rv_dout, 16'hBE34);
    // ds=00 write must ack yet leave memory alone
    rv_we = 1'b1; rv_din = 16'hFFFF; rv_ds = 2'b00; rv_req = 1'b0;
    go_to(26);
    chk("rv_ds00_ack", {15'd0, rv_req_ack}, 16'h0000);
    rv_we = 1'b0; rv_req = 1'b1;
    go_to(29);
    chk("rv_ds00_mem", rv_dout, 16'hBE34);

    // clkref rising at edge 30 realigns: port1 read served at 32, not 31
    clkref = 1'b1;
    oe[1] = 1'b1; addr[43:22] = 22'h000123;
    go_to(30);
    clkref = 1'b0; oe[1] = 1'b0;
    go_to(32);
    chk("clkref_hold", dout, 16'h2211);
    go_to(33);
    chk("clkref_served", dout, 16'h5A11);

    // reset with port0 write pending and RV request outstanding
    we[0] = 1'b1; addr[21:0] = 22'h000123; din[7:0] = 8'hEE;
    go_to(34);
    we[0] = 1'b0; resetn = 1'b0;
    rv_we = 1'b1; rv_din = 16'h5555; rv_ds = 2'b11;
    go_to(37);
    chk("mid_rst_dout", dout, 16'h0000);
    chk("mid_rst_ack", {15'd0, rv_req_ack}, 16'h0000);
    chk("mid_rst_rv_dout", rv_dout, 16'h0000);
    rv_req = 1'b0; rv_we = 1'b0; resetn = 1'b1;
    oe[0] = 1'b1;                      // capture 38, slot 39, data 40
    go_to(38);
    oe[0] = 1'b0;
    go_to(39);
    chk("post_rst_early", dout, 16'h0000);
    go_to(40);
    chk("post_rst_no_wr", dout, 16'h005A);
    rv_req = 1'b1;
    go_to(41);
    chk("post_rst_rv_pre", {15'd0, rv_req_ack}, 16'h0000);
    go_to(42);
    chk("post_rst_rv_ack", {15'd0, rv_req_ack}, 16'h0001);
    go_to(43);
    chk("post_rst_rv_mem", rv_dout, 16'hBE34);

    // refresh instance: released at 43, busy opens after edge 59
    resetn_r = 1'b1;
    we_r[0] = 1'b1; addr_r[11:0] = 12'h055; din_r[7:0] = 8'hC3;
    go_to(44);
    we_r[0] = 1'b0;
    go_to(58);
    chk("ref_busy_pre", {15'd0, busy_r}, 16'h0000);
    go_to(59);
    chk("ref_busy_on", {15'd0, busy_r}, 16'h0001);
    oe_r[0] = 1'b1;
    rv_addr_r = 8'h03; rv_din_r = 16'h0A0B; rv_ds_r = 2'b11; rv_we_r = 1'b1; rv_req_r = 1'b1;
    go_to(60);
    oe_r[0] = 1'b0;
    go_to(62);
    chk("ref_busy_last", {15'd0, busy_r}, 16'h0001);
    chk("ref_dout_held", dout_r, 16'h0000);
    go_to(63);
    chk("ref_busy_off", {15'd0, busy_r}, 16'h0000);
    chk("ref_ack_held", {15'd0, rv_req_ack_r}, 16'h0000);
    go_to(64);
    chk("ref_ack", {15'd0, rv_req_ack_r}, 16'h0001);
    go_to(65);
    chk("ref_rd_early", dout_r, 16'h0000);
    go_to(66);
    chk("ref_rd_served", dout_r, 16'h00C3);
    go_to(74);
    chk("ref2_busy_pre", {15'd0, busy_r}, 16'h0000);
    go_to(75);
    chk("ref2_busy_on", {15'd0, busy_r}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
